vdg_mem_scheduler: RTL and testbench

Shares the single video/system RAM between the CPU and the ProtoVDG display fetch, in the manner of a SAM-style controller. Generates the VDG display address from a programmable base and a per-mode row-repeat count, and tracks DA0/HSn/FSn from the VDG. Fetches display bytes onto the VDG Data bus with strict video priority. Serves CPU reads and writes in the remaining memory cycles.

---
 rtl/vdg_mem_scheduler_pkg.sv | 27 ++
 rtl/vdg_mem_scheduler_if.sv | 21 ++
 rtl/vdg_addr_gen.sv | 70 +++++++
 rtl/vdg_mem_scheduler.sv | 139 +++++++++++++
 tb/tb_vdg_mem_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdg_mem_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vdg_mem_pkg
//  Description : Shared types and constants for the VDG memory scheduler:
//                arbiter state encoding, per-mode row-repeat table and the
//                scan-line counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package vdg_mem_pkg;

    // Arbiter states; VID/CPU issue the RAM cycle, *_WAIT consume read data
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VID      = 3'd1,
        VID_WAIT = 3'd2,
        CPU      = 3'd3,
        CPU_WAIT = 3'd4
    } state_t;

    localparam int LINE_W = 4;

    // Scan lines per display row, indexed by mode (element 0 = mode 0)
    localparam logic [7:0][LINE_W-1:0] ROW_REPEAT =
        {4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd12};

endpackage
`default_nettype wire

// File: rtl/vdg_mem_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : vdg_mem_scheduler_if
//  Description : CPU request/acknowledge bus. The requester holds req, we,
//                addr and wdata until it sees ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface vdg_mem_scheduler_if #(
    parameter int ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              ack;
    logic [7:0]        rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/vdg_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vdg_addr_gen
//  Description : Display address generator. Detects HSn/FSn falling edges,
//                reloads the base on field sync, repeats or advances the
//                display row on line sync, and steps the address per fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module vdg_addr_gen
    import vdg_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BASE_W = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [BASE_W-1:0] base_addr,
    input  logic [2:0]        mode,
    input  logic              HSn,
    input  logic              FSn,
    input  logic              advance,
    output logic              fs_fall,
    output logic [ADDR_W-1:0] vid_addr
);

    logic              hs_q;
    logic              fs_q;
    logic              hs_fall;
    logic [ADDR_W-1:0] row_start;
    logic [ADDR_W-1:0] base_byte;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W-1:0] last_line;

    assign hs_fall   = hs_q & ~HSn;
    assign fs_fall   = fs_q & ~FSn;
    assign base_byte = {base_addr, {(ADDR_W-BASE_W){1'b0}}};
    assign last_line = ROW_REPEAT[mode] - LINE_W'(1);

    // Sync edge history plus address/row/line update; sync edges beat the fetch step
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs_q      <= 1'b1;
            fs_q      <= 1'b1;
            vid_addr  <= '0;
            row_start <= '0;
            line_cnt  <= '0;
        end else begin
            hs_q <= HSn;
            fs_q <= FSn;
            if (fs_fall) begin
                vid_addr  <= base_byte;
                row_start <= base_byte;
                line_cnt  <= '0;
            end else if (hs_fall) begin
                // >= keeps a mid-field mode shrink from running the count past the end
                if (line_cnt >= last_line) begin
                    row_start <= vid_addr;
                    line_cnt  <= '0;
                end else begin
                    vid_addr <= row_start;
                    line_cnt <= line_cnt + LINE_W'(1);
                end
            end else if (advance) begin
                vid_addr <= vid_addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vdg_mem_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : vdg_mem_scheduler
//  Description : SAM-style arbiter sharing one synchronous RAM between the
//                VDG display fetch (strict priority) and CPU accesses.
//                Optional macro VDG_OVERRUN_EN adds the sticky vdg_overrun
//                flag for DA0 strobes arriving while a fetch is pending.
//  Revision    : 1.0  initial release
// ============================================================================
module vdg_mem_scheduler
    import vdg_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BASE_W = 7
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [BASE_W-1:0]       base_addr,
    input  logic [2:0]              mode,
    input  logic                    DA0,
    input  logic                    HSn,
    input  logic                    FSn,
    vdg_mem_scheduler_if.slave      cpu,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    output logic [7:0]              vdg_data,
    output logic                    vdg_valid
`ifdef VDG_OVERRUN_EN
    ,
    output logic                    vdg_overrun
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic              da0_q;
    logic              da0_rise;
    logic              vid_pend;
    logic              pend_eff;
    logic              fs_fall;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vdg_data_q;
    logic [7:0]        cpu_rdata_q;

    vdg_addr_gen #(
        .ADDR_W (ADDR_W),
        .BASE_W (BASE_W)
    ) u_addr_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .base_addr (base_addr),
        .mode      (mode),
        .HSn       (HSn),
        .FSn       (FSn),
        .advance   (state == VID),
        .fs_fall   (fs_fall),
        .vid_addr  (vid_addr)
    );

    // A fresh DA0 rise is acted on in the same cycle it is seen; field sync drops stale requests
    assign da0_rise = DA0 & ~da0_q;
    assign pend_eff = da0_rise | (vid_pend & ~fs_fall);

    // State register, DA0 history, pending fetch flag and held read data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            da0_q       <= 1'b0;
            vid_pend    <= 1'b0;
            vdg_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state    <= state_nxt;
            da0_q    <= DA0;
            vid_pend <= da0_rise | (vid_pend & ~fs_fall & (state != VID));
            if (state == VID_WAIT)
                vdg_data_q <= mem_rdata;
            if ((state == CPU_WAIT) && !cpu.we)
                cpu_rdata_q <= mem_rdata;
        end
    end

    // Next state: video always wins a free slot, CPU accesses are never cut short
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, VID_WAIT, CPU_WAIT: begin
                if (pend_eff)
                    state_nxt = VID;
                else if (cpu.req)
                    state_nxt = CPU;
                else
                    state_nxt = IDLE;
            end
            VID:     state_nxt = VID_WAIT;
            CPU:     state_nxt = CPU_WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes and returned data are decoded from the current state
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == VID) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (state == CPU) begin
            mem_en    = 1'b1;
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end
    end

    assign vdg_valid = (state == VID_WAIT);
    assign vdg_data  = vdg_valid ? mem_rdata : vdg_data_q;
    assign cpu.ack   = (state == CPU_WAIT);
    assign cpu.rdata = (cpu.ack && !cpu.we) ? mem_rdata : cpu_rdata_q;

`ifdef VDG_OVERRUN_EN
    // Sticky overrun: a DA0 rise while a fetch is still pending; field sync clears it
    always_ff @(posedge Clk) begin
        if (Reset)
            vdg_overrun <= 1'b0;
        else if (fs_fall)
            vdg_overrun <= 1'b0;
        else if (da0_rise && vid_pend)
            vdg_overrun <= 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vdg_mem_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vdg_mem_scheduler
//  Description : Self-checking bench for vdg_mem_scheduler with a behavioural
//                display-address/RAM model and randomized CPU traffic.
//                Honours VDG_OVERRUN_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vdg_mem_scheduler;

    typedef struct {
        logic [15:0] addr;
        int          t;
        int          maxlat;
    } vexp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [6:0]  base_addr;
    logic [2:0]  mode;
    logic        DA0, HSn, FSn;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, vdg_data;
    logic        vdg_valid;
`ifdef VDG_OVERRUN_EN
    logic        vdg_overrun;
`endif

    vdg_mem_scheduler_if #(.ADDR_W(16)) cpu_if ();

    vdg_mem_scheduler #(.ADDR_W(16), .BASE_W(7)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .base_addr (base_addr),
        .mode      (mode),
        .DA0       (DA0),
        .HSn       (HSn),
        .FSn       (FSn),
        .cpu       (cpu_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .vdg_data  (vdg_data),
        .vdg_valid (vdg_valid)
`ifdef VDG_OVERRUN_EN
        ,
        .vdg_overrun (vdg_overrun)
`endif
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_req = 0, n_wr = 0, n_ack = 0, n_we = 0;
    bit vid_chk = 1'b1;
    bit vid_done;

    // RAM device: preloaded pattern, overwritten per location once written
    bit [7:0] wmem [65536];
    bit       wv   [65536];
    // Reference copy of memory contents
    bit [7:0] gm   [65536];
    bit       gw   [65536];

    vexp_t       vq[$];
    logic [15:0] obs[$];

    // Display-address reference model
    logic [15:0] m_addr, m_row;
    int          m_line;
    int          rep_tab[8] = '{12, 3, 3, 2, 2, 1, 1, 1};

    logic        p_en, p_we;
    logic [15:0] p_addr;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] gold(input logic [15:0] a);
        return gw[a] ? gm[a] : pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) begin
                wmem[mem_addr] <= mem_wdata;
                wv[mem_addr]   <= 1'b1;
            end
            mem_rdata <= wv[mem_addr] ? wmem[mem_addr] : pat(mem_addr);
        end
    end

    // Every-cycle compare of the display fetch stream against the model queue
    always @(negedge Clk) begin
        if (cpu_if.ack) n_ack++;
        if (mem_we) n_we++;
        if (vdg_valid && vid_chk) begin
            if (vq.size() == 0) begin
                chk("vid_unexpected_valid", 1, 0);
            end else begin
                vexp_t e;
                e = vq.pop_front();
                chk("vid_fetch_cycle", {p_en, p_we}, 2'b10);
                chk("vid_fetch_addr", p_addr, e.addr);
                chk("vid_data", vdg_data, gold(e.addr));
                chk_rng("vid_latency", cyc - e.t, 2, e.maxlat);
                obs.push_back(p_addr);
            end
        end
        p_en   = mem_en;
        p_we   = mem_we;
        p_addr = mem_addr;
    end

    task automatic fs_pulse();
        @(posedge Clk); #1;
        FSn = 1'b0;
        m_addr = {base_addr, 9'b0};
        m_row  = m_addr;
        m_line = 0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        FSn = 1'b1;
    endtask

    task automatic hs_pulse();
        @(posedge Clk); #1;
        HSn = 1'b0;
        if (m_line == rep_tab[mode] - 1) begin
            m_row  = m_addr;
            m_line = 0;
        end else begin
            m_line = m_line + 1;
            m_addr = m_row;
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        HSn = 1'b1;
    endtask

    task automatic da0_pulse(input int maxlat, input int spacing);
        @(posedge Clk); #1;
        vq.push_back('{m_addr, cyc, maxlat});
        m_addr = m_addr + 16'd1;
        DA0 = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        DA0 = 1'b0;
        repeat (spacing - 3) @(posedge Clk);
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int start_t, output int ack_t);
        logic        got, q_en, q_we;
        logic [15:0] q_addr;
        logic [7:0]  q_wd, exp;
        @(posedge Clk); #1;
        cpu_if.req   = 1'b1;
        cpu_if.we    = we;
        cpu_if.addr  = addr;
        cpu_if.wdata = wd;
        start_t = cyc;
        ack_t   = -1;
        rd      = '0;
        exp     = gold(addr);
        n_req++;
        if (we) n_wr++;
        got = 1'b0;
        q_en = 1'b0; q_we = 1'b0; q_addr = '0; q_wd = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge Clk);
            if (cpu_if.ack) begin
                got = 1'b1;
                chk("cpu_mem_cycle", {q_en, q_we, q_addr, (we ? q_wd : 8'h00)},
                    {1'b1, we, addr, (we ? wd : 8'h00)});
                if (!we) chk("cpu_rdata", cpu_if.rdata, exp);
                rd    = cpu_if.rdata;
                ack_t = cyc;
                cpu_if.req = 1'b0;
                if (we) begin
                    gm[addr] = wd;
                    gw[addr] = 1'b1;
                end
            end else begin
                q_en = mem_en; q_we = mem_we; q_addr = mem_addr; q_wd = mem_wdata;
            end
        end
        if (!got) begin
            chk("cpu_ack_timeout", 0, 1);
            cpu_if.req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         t0, t1, ls[13], we0, any;
        Reset = 1'b1; base_addr = '0; mode = '0; DA0 = 1'b0; HSn = 1'b1; FSn = 1'b1;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        m_addr = '0; m_row = '0; m_line = 0;
        repeat (4) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, cpu_if.ack, cpu_if.rdata,
                              vdg_data, vdg_valid}, '0);
`ifdef VDG_OVERRUN_EN
        chk("reset_overrun", vdg_overrun, 0);
`endif

        // Fetch sequence from base page 2
        base_addr = 7'h02; mode = 3'd6;
        fs_pulse();
        for (int i = 0; i < 4; i++) da0_pulse(2, 6);
        repeat (4) @(posedge Clk);
        for (int i = 0; i < 4; i++) chk("first_fetch_addr", obs[i], 16'h0400 + 16'(i));

        // Mode 0: twelve scan lines per row
        mode = 3'd0;
        fs_pulse();
        for (int l = 0; l < 13; l++) begin
            ls[l] = obs.size();
            for (int k = 0; k < 32; k++) da0_pulse(2, 6);
            if (l < 12) hs_pulse();
        end
        repeat (4) @(posedge Clk);
        for (int l = 0; l < 12; l++) chk("row_repeat_start", obs[ls[l]], 16'h0400);
        chk("row_advance_start", obs[ls[12]], 16'h0420);

        // Collision: CPU read raised together with a DA0 rise
        fork
            da0_pulse(2, 6);
            cpu_access(1'b0, 16'h1234, 8'h00, rd, t0, t1);
        join
        chk("collision_ack_delay", t1 - t0, 4);
        chk("collision_rdata", rd, 8'h34 ^ 8'h12 ^ 8'h5A);

        // Write then read back
        @(negedge Clk); we0 = n_we;
        cpu_access(1'b1, 16'h2000, 8'hA5, rd, t0, t1);
        @(negedge Clk);
        chk("write_we_pulses", n_we - we0, 1);
        cpu_access(1'b0, 16'h2000, 8'h00, rd, t0, t1);
        chk("readback", rd, 8'hA5);

        // Randomized fields with concurrent CPU traffic
        vid_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    base_addr = 7'($urandom_range(0, 63));
                    mode      = 3'($urandom_range(0, 7));
                    fs_pulse();
                    for (int l = $urandom_range(4, 6); l > 0; l--) begin
                        for (int k = $urandom_range(4, 8); k > 0; k--)
                            da0_pulse(3, $urandom_range(6, 9));
                        hs_pulse();
                    end
                end
                vid_done = 1'b1;
            end
            begin
                logic [7:0] r2;
                int a, b;
                while (!vid_done) begin
                    repeat ($urandom_range(0, 4)) @(posedge Clk);
                    cpu_access(1'($urandom_range(0, 1)), 16'h8000 | 16'($urandom_range(0, 32767)),
                               8'($urandom_range(0, 255)), r2, a, b);
                end
            end
        join
        repeat (6) @(posedge Clk);
`ifdef VDG_OVERRUN_EN
        chk("no_overrun_at_normal_rate", vdg_overrun, 0);
`endif

        // Sync precedence: FSn and HSn fall during a VID cycle
        base_addr = 7'h03; mode = 3'd3;
        fs_pulse();
        da0_pulse(2, 6);
        @(posedge Clk); #1;
        vq.push_back('{m_addr, cyc, 2});
        DA0 = 1'b1;
        @(posedge Clk); #1;
        HSn = 1'b0; FSn = 1'b0;
        m_addr = {base_addr, 9'b0}; m_row = m_addr; m_line = 0;
        @(posedge Clk); #1;
        DA0 = 1'b0;
        @(posedge Clk); #1;
        HSn = 1'b1; FSn = 1'b1;
        repeat (3) @(posedge Clk);
        da0_pulse(2, 6);
        da0_pulse(2, 6);
        repeat (3) @(posedge Clk);
        chk("sync_prec_fetch", obs[obs.size()-2], 16'h0600);
        hs_pulse();
        da0_pulse(2, 6);
        repeat (3) @(posedge Clk);
        chk("sync_prec_line_repeat", obs[obs.size()-1], 16'h0600);

`ifdef VDG_OVERRUN_EN
        // DA0 every 2 cycles while a CPU access holds the RAM
        vid_chk = 1'b0;
        fork
            cpu_access(1'b0, 16'h9000, 8'h00, rd, t0, t1);
            begin
                @(posedge Clk); #1;
                @(posedge Clk); #1; DA0 = 1'b1;
                @(posedge Clk); #1; DA0 = 1'b0;
                @(posedge Clk); #1; DA0 = 1'b1;
                @(posedge Clk); #1; DA0 = 1'b0;
            end
        join
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        chk("overrun_set", vdg_overrun, 1);
        fs_pulse();
        @(negedge Clk);
        chk("overrun_cleared_by_fs", vdg_overrun, 0);
        repeat (4) @(posedge Clk);
        vid_chk = 1'b1;
`endif

        // Reset while a CPU access is in its RAM cycle
        @(posedge Clk); #1;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h8123;
        any = 0;
        for (int i = 0; i < 10 && any == 0; i++) begin
            @(negedge Clk);
            if (mem_en && mem_addr == 16'h8123) any = 1;
        end
        chk("reset_test_cpu_cycle_seen", any, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, cpu_if.ack, cpu_if.rdata,
                                  vdg_data, vdg_valid}, '0);
        @(posedge Clk); #1;
        Reset = 1'b0; cpu_if.req = 1'b0;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (cpu_if.ack) any = 1;
        end
        chk("no_ack_after_reset", any, 0);
        m_addr = '0; m_row = '0; m_line = 0;
        da0_pulse(2, 6);
        repeat (3) @(posedge Clk);
        chk("addr_cleared_by_reset", obs[obs.size()-1], 16'h0000);

        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("vid_queue_drained", vq.size(), 0);
        chk("one_ack_per_request", n_ack, n_req);
        chk("we_pulses_per_write", n_we, n_wr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
